// File: rtl/mistral_carry_seq.sv
// mistral_carry_seq
//   Digit-serial add/subtract sequencer sharing one 2-bit carry slice among
//   N_REQ requesters. Each RUN cycle resolves one 2-bit digit:
//     {c, s0} = A + B + Cin ; {Cout, s1} = C + D + c
//   so a WIDTH-bit operation occupies the slice for WIDTH/2 cycles.
//
// Ports
//   CLK        clock, all state on rising edge
//   AC         synchronous active-high reset
//   REQ_VALID  per-requester request
//   REQ_SUB    per-requester: 1 = A-B, 0 = A+B
//   REQ_A/B    operands, requester i at [i*WIDTH +: WIDTH]
//   REQ_READY  one-hot accept strobe (combinational, IDLE only)
//   RSP_VALID  result available, held until RSP_READY
//   RSP_ID     owner of the result
//   RSP_SUM    result bits
//   RSP_COUT   carry out of MSB (subtract: 1 = no borrow)
//   RSP_OVF    signed overflow
//   RSP_READY  consumer accepts the result
module mistral_carry_seq #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   AC,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [N_REQ-1:0]       REQ_SUB,
  input  logic [N_REQ*WIDTH-1:0] REQ_A,
  input  logic [N_REQ*WIDTH-1:0] REQ_B,
  output logic [N_REQ-1:0]       REQ_READY,
  output logic                   RSP_VALID,
  output logic [ID_W-1:0]        RSP_ID,
  output logic [WIDTH-1:0]       RSP_SUM,
  output logic                   RSP_COUT,
  output logic                   RSP_OVF,
  input  logic                   RSP_READY
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              carry_q, carry_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              vld_q, vld_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [1:0]        lo, hi;
  logic [WIDTH-1:0]  win_b;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(ptr_q) + 32'd1 + i) % N_REQ);
      if (!win_found && REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (AC) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    win_b   = WIDTH'(REQ_B >> (32'(win_idx) * WIDTH));
    // Operands shift right one digit per cycle, so the slice always
    // consumes bits [1:0]; the sum digit is placed back at position k.
    lo = {1'b0, op_a_q[0]} + {1'b0, op_b_q[0]} + {1'b0, carry_q};
    hi = {1'b0, op_a_q[1]} + {1'b0, op_b_q[1]} + {1'b0, lo[1]};

    case (state_q)
      IDLE: begin
        if (win_found) begin
          op_a_d  = WIDTH'(REQ_A >> (32'(win_idx) * WIDTH));
          op_b_d  = REQ_SUB[win_idx] ? ~win_b : win_b;
          carry_d = REQ_SUB[win_idx];
          id_d    = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> 2;
        op_b_d  = op_b_q >> 2;
        sum_d   = (sum_q & ~(WIDTH'(2'b11) << {cnt_q, 1'b0}))
                | (WIDTH'({hi[0], lo[0]}) << {cnt_q, 1'b0});
        carry_d = hi[1];
        if (cnt_q == CNT_LAST) begin
          cout_d  = hi[1];
          ovf_d   = lo[1] ^ hi[1];
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (RSP_READY) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    REQ_READY = '0;
    if (state_q == IDLE && win_found) REQ_READY[win_idx] = 1'b1;
  end

  assign RSP_VALID = vld_q;
  assign RSP_ID    = id_q;
  assign RSP_SUM   = sum_q;
  assign RSP_COUT  = cout_q;
  assign RSP_OVF   = ovf_q;

endmodule
